// File: rtl/mips_cpu_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control path: FSM states,
// opcode/function fields and the instruction classes the sequencer acts on.
package mips_cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_NOP,
    CL_ALU_R,
    CL_ALU_I,
    CL_LOAD,
    CL_STORE,
    CL_BRANCH,
    CL_J,
    CL_JAL,
    CL_JR,
    CL_MULDIV
  } instr_class_t;

  localparam logic [5:0] OP_RTYPE  = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_ADDIU  = 6'h09;
  localparam logic [5:0] OP_SLTI   = 6'h0A;
  localparam logic [5:0] OP_SLTIU  = 6'h0B;
  localparam logic [5:0] OP_ANDI   = 6'h0C;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_XORI   = 6'h0E;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LWL    = 6'h22;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_LHU    = 6'h25;
  localparam logic [5:0] OP_LWR    = 6'h26;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_SLL    = 6'h00;
  localparam logic [5:0] FN_SRL    = 6'h02;
  localparam logic [5:0] FN_SRA    = 6'h03;
  localparam logic [5:0] FN_SLLV   = 6'h04;
  localparam logic [5:0] FN_SRLV   = 6'h06;
  localparam logic [5:0] FN_SRAV   = 6'h07;
  localparam logic [5:0] FN_JR     = 6'h08;
  localparam logic [5:0] FN_JALR   = 6'h09;
  localparam logic [5:0] FN_MFHI   = 6'h10;
  localparam logic [5:0] FN_MTHI   = 6'h11;
  localparam logic [5:0] FN_MFLO   = 6'h12;
  localparam logic [5:0] FN_MTLO   = 6'h13;
  localparam logic [5:0] FN_MULT   = 6'h18;
  localparam logic [5:0] FN_MULTU  = 6'h19;
  localparam logic [5:0] FN_DIV    = 6'h1A;
  localparam logic [5:0] FN_DIVU   = 6'h1B;
  localparam logic [5:0] FN_ADD    = 6'h20;
  localparam logic [5:0] FN_ADDU   = 6'h21;
  localparam logic [5:0] FN_SUB    = 6'h22;
  localparam logic [5:0] FN_SUBU   = 6'h23;
  localparam logic [5:0] FN_AND    = 6'h24;
  localparam logic [5:0] FN_OR     = 6'h25;
  localparam logic [5:0] FN_XOR    = 6'h26;
  localparam logic [5:0] FN_NOR    = 6'h27;
  localparam logic [5:0] FN_SLT    = 6'h2A;
  localparam logic [5:0] FN_SLTU   = 6'h2B;

endpackage

// File: rtl/mips_cpu_instr_classify.sv
// Combinational decode of the IR op/func fields into the instruction class
// that selects the sequencer's EXEC/MEM/WB path.
module mips_cpu_instr_classify
  import mips_cpu_ctrl_pkg::*;
(
  input  logic [5:0]   op,
  input  logic [5:0]   func,
  output instr_class_t cls
);

  always_comb begin
    cls = CL_NOP;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
          FN_MFHI, FN_MFLO,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU: cls = CL_ALU_R;
          FN_JR:                                          cls = CL_JR;
          FN_JALR:                                        cls = CL_JAL;
          // HI/LO moves touch only ALU-internal registers, like MULT/DIV
          FN_MTHI, FN_MTLO,
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:             cls = CL_MULDIV;
          default:                                        cls = CL_NOP;
        endcase
      end
      OP_REGIMM, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CL_BRANCH;
      OP_J:                                        cls = CL_J;
      OP_JAL:                                      cls = CL_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:            cls = CL_ALU_I;
      OP_LB, OP_LH, OP_LWL, OP_LW,
      OP_LBU, OP_LHU, OP_LWR:                      cls = CL_LOAD;
      OP_SB, OP_SH, OP_SW:                         cls = CL_STORE;
      default:                                     cls = CL_NOP;
    endcase
  end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// Multicycle MIPS sequencer: FETCH/DECODE/EXEC/MEM/WB with memory
// waitrequest handshake, multi-cycle ALU stall and a terminal HALT.
module mips_cpu_control_fsm
  import mips_cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       pc_is_zero,
  input  logic       mem_waitrequest,
  input  logic       alu_busy,
  output logic       active,
  output logic       ir_write,
  output logic       ir_sel,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       reg_write,
  output logic [2:0] state_o
);

  state_t       state, state_nxt;
  instr_class_t cls;
  logic         armed;

  mips_cpu_instr_classify u_classify (
    .op   (op),
    .func (func),
    .cls  (cls)
  );

  // armed is cleared by reset so the first FETCH after it issues nothing;
  // any memory request pending at the reset edge is thereby dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_FETCH;
      armed <= 1'b0;
    end else begin
      state <= state_nxt;
      armed <= 1'b1;
    end
  end

  always_comb begin
    state_nxt     = state;
    ir_write      = 1'b0;
    ir_sel        = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    reg_write     = 1'b0;
    case (state)
      ST_FETCH: begin
        if (armed) begin
          if (pc_is_zero) begin
            state_nxt = ST_HALT;
          end else begin
            mem_read = 1'b1;
            if (!mem_waitrequest) begin
              ir_write  = 1'b1;
              ir_sel    = 1'b1;
              pc_write  = 1'b1;
              state_nxt = ST_DECODE;
            end
          end
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        case (cls)
          CL_ALU_R, CL_ALU_I: state_nxt = ST_WB;
          CL_LOAD, CL_STORE:  state_nxt = ST_MEM;
          CL_BRANCH: begin
            pc_write_cond = 1'b1;
            state_nxt     = ST_FETCH;
          end
          CL_J, CL_JR: begin
            pc_write  = 1'b1;
            state_nxt = ST_FETCH;
          end
          CL_JAL: begin
            pc_write  = 1'b1;
            state_nxt = ST_WB;
          end
          CL_MULDIV: if (!alu_busy) state_nxt = ST_FETCH;
          default:   state_nxt = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        iord      = 1'b1;
        mem_read  = (cls == CL_LOAD);
        mem_write = (cls == CL_STORE);
        if (!mem_waitrequest) state_nxt = (cls == CL_LOAD) ? ST_WB : ST_FETCH;
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_nxt = ST_FETCH;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_FETCH;
    endcase
  end

  assign active  = (state != ST_HALT);
  assign state_o = state;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// Bench for mips_cpu_control_fsm: each instruction is expanded into its expected
// per-cycle phase list, which also supplies the stimulus; outputs checked per cycle.
module tb_mips_cpu_control_fsm;

  logic       clk = 1'b0;
  logic       reset, pc_is_zero, mem_waitrequest, alu_busy;
  logic [5:0] op, func;
  logic       active, ir_write, ir_sel, iord, mem_read, mem_write;
  logic       pc_write, pc_write_cond, reg_write;
  logic [2:0] state_o;

  always #5 clk = ~clk;

  mips_cpu_control_fsm dut (
    .clk             (clk),
    .reset           (reset),
    .op              (op),
    .func            (func),
    .pc_is_zero      (pc_is_zero),
    .mem_waitrequest (mem_waitrequest),
    .alu_busy        (alu_busy),
    .active          (active),
    .ir_write        (ir_write),
    .ir_sel          (ir_sel),
    .iord            (iord),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .pc_write        (pc_write),
    .pc_write_cond   (pc_write_cond),
    .reg_write       (reg_write),
    .state_o         (state_o)
  );

  localparam logic [2:0] S_F = 3'd0, S_D = 3'd1, S_X = 3'd2, S_M = 3'd3, S_W = 3'd4, S_H = 3'd5;
  // strobe vector: {active, ir_write, ir_sel, iord, mem_read, mem_write, pc_write, pc_write_cond, reg_write}
  localparam logic [8:0] A   = 9'h100, IRW = 9'h080, IRS = 9'h040, IOR = 9'h020, MRD = 9'h010;
  localparam logic [8:0] MWR = 9'h008, PCW = 9'h004, PCC = 9'h002, RGW = 9'h001;
  localparam int K_NOP = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_J = 5, K_LINK = 6, K_MD = 7;

  typedef struct {
    bit         rst, wr, busy, pcz, chk;
    logic [5:0] op, func;
    logic [2:0] st;
    logic [8:0] out;
  } rec_t;

  rec_t       q[$];
  int         n_chk = 0, n_bad = 0;
  logic [5:0] cur_op, cur_func;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%b exp=%b", tag, got, exp);
    end
  endtask

  function automatic bit rb();
    return 1'($urandom);
  endfunction

  function automatic int kind(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00) begin
      if (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
                    [6'h20:6'h27], 6'h2A, 6'h2B}) return K_ALU;
      if (f == 6'h08) return K_J;
      if (f == 6'h09) return K_LINK;
      if (f inside {6'h11, 6'h13, [6'h18:6'h1B]}) return K_MD;
      return K_NOP;
    end
    if (o inside {6'h01, [6'h04:6'h07]}) return K_BR;
    if (o == 6'h02) return K_J;
    if (o == 6'h03) return K_LINK;
    if (o inside {[6'h08:6'h0F]}) return K_ALU;
    if (o inside {[6'h20:6'h26]}) return K_LOAD;
    if (o inside {6'h28, 6'h29, 6'h2B}) return K_STORE;
    return K_NOP;
  endfunction

  // ir_valid=0: op/func are don't-care that cycle and get random values
  task automatic push(input logic [2:0] st, input logic [8:0] out, input bit wr, input bit busy,
                      input bit pcz, input bit ir_valid, input bit rst = 1'b0, input bit chk = 1'b1);
    rec_t r;
    r.st = st; r.out = out; r.wr = wr; r.busy = busy; r.pcz = pcz; r.rst = rst; r.chk = chk;
    r.op   = ir_valid ? cur_op   : 6'($urandom);
    r.func = ir_valid ? cur_func : 6'($urandom);
    q.push_back(r);
  endtask

  task automatic push_dead();
    push(S_F, A, rb(), rb(), rb(), 1'b0);
  endtask

  task automatic plan_instr(input logic [5:0] o, input logic [5:0] f, input int fw, input int mw,
                            input int bc, input bit abort);
    int         k;
    logic [8:0] mo;
    cur_op = o; cur_func = f; k = kind(o, f);
    for (int i = 0; i < fw; i++) push(S_F, A | MRD, 1'b1, rb(), 1'b0, 1'b0);
    push(S_F, A | MRD | IRW | IRS | PCW, 1'b0, rb(), 1'b0, 1'b0);
    push(S_D, A, rb(), rb(), rb(), 1'b1);
    case (k)
      K_BR:         push(S_X, A | PCC, rb(), rb(), rb(), 1'b1);
      K_J, K_LINK:  push(S_X, A | PCW, rb(), rb(), rb(), 1'b1);
      K_MD: begin
        for (int i = 0; i < bc; i++) push(S_X, A, rb(), 1'b1, rb(), 1'b1);
        push(S_X, A, rb(), 1'b0, rb(), 1'b1);
      end
      default:      push(S_X, A, rb(), rb(), rb(), 1'b1);
    endcase
    if (k == K_LOAD || k == K_STORE) begin
      mo = A | IOR | ((k == K_LOAD) ? MRD : MWR);
      for (int i = 0; i < mw; i++) begin
        if (abort && i == mw - 1) begin
          push(S_M, mo, 1'b1, rb(), rb(), 1'b1, 1'b1);
          push_dead();
          return;
        end
        push(S_M, mo, 1'b1, rb(), rb(), 1'b1);
      end
      push(S_M, mo, 1'b0, rb(), rb(), 1'b1);
    end
    if (k == K_ALU || k == K_LOAD || k == K_LINK) push(S_W, A | RGW, rb(), rb(), rb(), 1'b1);
  endtask

  task automatic plan_halt(input int n);
    push(S_F, A, rb(), rb(), 1'b1, 1'b0);
    for (int i = 0; i < n; i++) push(S_H, 9'h000, rb(), rb(), rb(), 1'b0);
    push(S_H, 9'h000, rb(), rb(), rb(), 1'b0, 1'b1);
    push_dead();
  endtask

  logic [5:0] known_op[15] = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h08, 6'h09, 6'h0F, 6'h20, 6'h23, 6'h28, 6'h2B};
  logic [5:0] known_fn[9]  = '{6'h21, 6'h08, 6'h09, 6'h18, 6'h1A, 6'h10, 6'h11, 6'h2A, 6'h0C};

  initial begin
    logic [5:0] o, f;
    int         mw;
    reset = 1'b1; pc_is_zero = 1'b0; mem_waitrequest = 1'b0; alu_busy = 1'b0;
    op = '0; func = '0;

    cur_op = '0; cur_func = '0;
    push(S_F, 9'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push_dead();
    plan_instr(6'h09, 6'h00, 0, 0, 0, 1'b0);   // ADDIU
    plan_instr(6'h23, 6'h00, 3, 2, 0, 1'b0);   // LW with waits
    plan_instr(6'h2B, 6'h00, 0, 0, 0, 1'b0);   // SW
    plan_instr(6'h04, 6'h00, 0, 0, 0, 1'b0);   // BEQ
    plan_instr(6'h00, 6'h18, 0, 0, 5, 1'b0);   // MULT, busy 5 cycles
    plan_instr(6'h23, 6'h00, 1, 3, 0, 1'b1);   // LW aborted by reset in MEM wait
    plan_instr(6'h03, 6'h00, 0, 0, 0, 1'b0);   // JAL
    plan_instr(6'h3F, 6'h00, 0, 0, 0, 1'b0);   // unknown op
    plan_instr(6'h00, 6'h08, 0, 0, 0, 1'b0);   // JR, then PC=0
    plan_halt(3);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        plan_halt($urandom_range(1, 4));
      end else begin
        o = ($urandom_range(0, 9) < 7) ? known_op[$urandom_range(0, 14)] : 6'($urandom);
        f = ($urandom_range(0, 9) < 7) ? known_fn[$urandom_range(0, 8)]  : 6'($urandom);
        mw = $urandom_range(0, 3);
        plan_instr(o, f, $urandom_range(0, 3), mw, $urandom_range(0, 4),
                   (mw > 0) && ($urandom_range(0, 9) == 0));
      end
    end

    @(posedge clk); #1;
    foreach (q[i]) begin
      reset = q[i].rst; mem_waitrequest = q[i].wr; alu_busy = q[i].busy;
      pc_is_zero = q[i].pcz; op = q[i].op; func = q[i].func;
      @(negedge clk);
      if (q[i].chk) begin
        check($sformatf("state[%0d] op=%h fn=%h", i, q[i].op, q[i].func), {6'b0, state_o}, {6'b0, q[i].st});
        check($sformatf("strobes[%0d] op=%h fn=%h", i, q[i].op, q[i].func),
              {active, ir_write, ir_sel, iord, mem_read, mem_write, pc_write, pc_write_cond, reg_write},
              q[i].out);
      end
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
